// File: rtl/axi_lite_uart.sv
// rtl/axi_lite_uart.sv - AXI-Lite 8N1 UART: TX FIFO, serializer, optional RX deserializer.
// Define UART_RX_EN to build the receive path.
module axi_lite_uart #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BAUD_DIV       = 868,
  parameter int TX_FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr_i,
  input  logic                        s_axi_awvalid_i,
  output logic                        s_axi_awready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                        s_axi_wvalid_i,
  output logic                        s_axi_wready_o,
  output logic [1:0]                  s_axi_bresp_o,
  output logic                        s_axi_bvalid_o,
  input  logic                        s_axi_bready_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr_i,
  input  logic                        s_axi_arvalid_i,
  output logic                        s_axi_arready_o,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]                  s_axi_rresp_o,
  output logic                        s_axi_rvalid_o,
  input  logic                        s_axi_rready_i,
  output logic                        tx,
  input  logic                        rx
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_RXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_DIV    = 2'd3;

  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rd_data;
  logic [15:0] div_q;
  logic        wr_fire, rd_fire;
  logic [1:0]  wr_sel, rd_sel;

  assign wr_fire = s_axi_awvalid_i & s_axi_wvalid_i & ~bvalid_q;
  assign rd_fire = s_axi_arvalid_i & ~rvalid_q;
  assign wr_sel  = s_axi_awaddr_i[3:2];
  assign rd_sel  = s_axi_araddr_i[3:2];

  assign s_axi_awready_o = wr_fire;
  assign s_axi_wready_o  = wr_fire;
  assign s_axi_arready_o = rd_fire;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = 2'b00;

  logic unused_axi;
  assign unused_axi = ^{s_axi_awaddr_i[AXI_ADDR_WIDTH-1:4], s_axi_awaddr_i[1:0],
                        s_axi_araddr_i[AXI_ADDR_WIDTH-1:4], s_axi_araddr_i[1:0],
                        s_axi_wdata_i[AXI_DATA_WIDTH-1:16], s_axi_wstrb_i};

  // TX FIFO; an empty FIFO hands the incoming byte straight to an idle serializer
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty, push_req, push_ok, tx_pop, tx_avail;
  logic [7:0]    fifo_head;
  logic [4:0]    count5;

  assign fifo_full  = (count_q == CW'(TX_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_req   = wr_fire & (wr_sel == A_TXDATA);
  assign push_ok    = push_req & (~fifo_full | tx_pop);
  assign tx_avail   = ~fifo_empty | push_req;
  assign fifo_head  = fifo_empty ? s_axi_wdata_i[7:0] : fifo_mem[rd_ptr_q];
  assign count5     = 5'(count_q);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= s_axi_wdata_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !tx_pop)      count_q <= count_q + CW'(1);
      else if (!push_ok && tx_pop) count_q <= count_q - CW'(1);
    end
  end

  // TX serializer
  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_bit_end, tx_busy;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_busy    = (tx_state_q != S_IDLE);
  assign tx         = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_avail) begin
          tx_pop     = 1'b1;
          tx_state_d = S_START;
          tx_shift_d = fifo_head;
          tx_div_d   = div_q;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = S_DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_idx_d   = tx_idx_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_idx_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_d = tx_shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_avail) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_shift_d = fifo_head;
            tx_div_d   = div_q;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(BAUD_DIV);
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  logic       rx_valid, rx_overrun;
  logic [7:0] rx_byte;

`ifdef UART_RX_EN
  logic [1:0]  rx_sync_q, rx_state_q, rx_state_d;
  logic        rx_prev_q, rx_line, rx_done, rxdata_rd, status_rd;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q;
  logic        rx_valid_q, rx_overrun_q;

  assign rx_line    = rx_sync_q[1];
  assign rxdata_rd  = rd_fire & (rd_sel == A_RXDATA) & rx_valid_q;
  assign status_rd  = rd_fire & (rd_sel == A_STATUS);
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_byte    = rx_byte_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_line) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
        end
      end
      S_START: begin
        // Half a bit in: a line that is high again was a glitch
        if (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          rx_done    = rx_line;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= 16'(BAUD_DIV);
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[0], rx};
      rx_prev_q    <= rx_line;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      if (rx_done) rx_byte_q <= rx_shift_q;
      rx_valid_q   <= rx_done | (rx_valid_q & ~rxdata_rd);
      rx_overrun_q <= (rx_done & rx_valid_q & ~rxdata_rd) | (rx_overrun_q & ~status_rd);
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = rx;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_byte    = 8'h00;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      A_RXDATA: rd_data = {rx_valid, 23'b0, rx_byte};
      A_STATUS: rd_data = {19'b0, count5, 3'b0, rx_overrun, rx_valid, tx_busy, fifo_empty, fifo_full};
      A_DIV:    rd_data = {16'b0, div_q};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      div_q    <= 16'(BAUD_DIV);
    end else begin
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (push_req && !push_ok) ? 2'b10 : 2'b00;
        if (wr_sel == A_DIV)
          div_q <= (s_axi_wdata_i[15:0] < 16'd4) ? 16'd4 : s_axi_wdata_i[15:0];
      end else if (s_axi_bready_i) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (s_axi_rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_uart.sv
// tb/tb_axi_lite_uart.sv - self-checking bench for axi_lite_uart (RX checks when UART_RX_EN is defined).
module tb_axi_lite_uart;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] awaddr, araddr;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic        tx_w, rx_w, rx_drv, loop_en;

  always #5 clk = ~clk;
  assign rx_w = loop_en ? tx_w : rx_drv;

  axi_lite_uart dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .tx(tx_w), .rx(rx_w)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial line monitor: every frame must match the next expected byte, bit for bit, cycle for cycle
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         mon_div = 16;
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;
  logic       mon_prev = 1'b1;
  logic [9:0] mon_frame;
  bit         mon_ok;
  logic [7:0] mon_b;

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        mon_prev = 1'b1;
      end else if (mon_prev && !tx_w) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_frame: got a start bit, expected none");
          mon_b = 8'h00;
        end else begin
          mon_b = exp_q.pop_front();
        end
        mon_frame = {1'b1, mon_b, 1'b0};
        mon_ok = 1'b1;
        for (int m = 0; m < 10 * mon_div; m++) begin
          if (m > 0) @(negedge clk);
          if (tx_w !== mon_frame[m / mon_div]) mon_ok = 1'b0;
        end
        check($sformatf("tx_frame_%02h", mon_b), {31'b0, mon_ok}, 32'd1);
        mon_prev = 1'b1;
        mon_busy = 1'b0;
      end else begin
        mon_prev = tx_w;
      end
    end
  end

  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int t = 0;
    awaddr = 64'(a); wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!awready && t < 50) begin @(posedge clk); #2; t++; end
    if (!awready) begin
      n_chk++; n_fail++;
      $display("FAIL wr_timeout: got no awready, expected handshake at 0x%0h", a);
      resp = 2'b11;
    end else begin
      @(posedge clk); #1;
      resp = bvalid ? bresp : 2'b11;
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
    int t = 0;
    araddr = 64'(a); arvalid = 1'b1;
    #1;
    while (!arready && t < 50) begin @(posedge clk); #2; t++; end
    if (!arready) begin
      n_chk++; n_fail++;
      $display("FAIL rd_timeout: got no arready, expected handshake at 0x%0h", a);
      d = 32'hDEAD_DEAD;
    end else begin
      @(posedge clk); #1;
      d = rvalid ? rdata : 32'hDEAD_DEAD;
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < limit) begin @(posedge clk); t++; end
    if (t >= limit) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: got %0d bytes pending, expected 0", exp_q.size());
    end
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[$];
  logic [1:0]  resp;
  logic [31:0] rd;
  int          div, n;
  logic [7:0]  b;

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
    wdata = '0; wstrb = 4'hF; bready = 1'b1; rready = 1'b1; rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'b0, tx_w}, 32'd1);
    check("reset_bvalid", {31'b0, bvalid}, 32'd0);
    check("reset_rvalid", {31'b0, rvalid}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Register map vectors: reads compare rdata, writes compare bresp
    vt.push_back('{0, 4'h8, 32'h0,         32'h0000_0002});
    vt.push_back('{0, 4'hC, 32'h0,         32'd868});
    vt.push_back('{0, 4'h0, 32'h0,         32'h0});
    vt.push_back('{0, 4'h4, 32'h0,         32'h0});
    vt.push_back('{1, 4'hC, 32'h1,         32'h0});
    vt.push_back('{0, 4'hC, 32'h0,         32'h4});
    vt.push_back('{1, 4'hC, 32'hFFFF_0010, 32'h0});
    vt.push_back('{0, 4'hC, 32'h0,         32'h10});
    vt.push_back('{1, 4'hC, 32'h0,         32'h0});
    vt.push_back('{0, 4'hC, 32'h0,         32'h4});
    vt.push_back('{1, 4'hC, 32'h0000_ABCD, 32'h0});
    vt.push_back('{0, 4'hC, 32'h0,         32'hABCD});
    vt.push_back('{1, 4'h8, 32'hFF,        32'h0});
    vt.push_back('{0, 4'h8, 32'h0,         32'h0000_0002});
    vt.push_back('{1, 4'h4, 32'h55,        32'h0});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) begin
        axi_wr(vt[i].addr, vt[i].data, resp);
        check($sformatf("vec%0d_bresp", i), {30'b0, resp}, vt[i].exp);
      end else begin
        axi_rd(vt[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      end
    end

    // One 0xA5 frame at 16 cycles per bit
    axi_wr(4'hC, 32'd16, resp);
    mon_div = 16; mon_en = 1'b1;
    exp_q.push_back(8'hA5);
    axi_wr(4'h0, 32'hA5, resp);
    check("a5_bresp", {30'b0, resp}, 32'd0);
    check("a5_start_latency", {31'b0, tx_w}, 32'd0);
    wait_done(400);
    axi_rd(4'h8, rd);
    check("a5_status_idle", rd, 32'h0000_0002);

    // Random bursts: frames must follow each other with no gap
    for (int r = 0; r < 6; r++) begin
      div = (r == 0) ? 4 : int'($urandom_range(4, 12));
      n = int'($urandom_range(2, 5));
      axi_wr(4'hC, 32'(div), resp);
      mon_div = div;
      start_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        axi_wr(4'h0, {24'b0, b}, resp);
        check("burst_bresp", {30'b0, resp}, 32'd0);
      end
      wait_done(20 * div * n + 100);
      check("burst_frames", 32'(start_q.size()), 32'(n));
      for (int k = 1; k < start_q.size(); k++)
        check("burst_gap", 32'(start_q[k] - start_q[k-1]), 32'(10 * div));
    end

    // Fill the FIFO behind a slow frame, then reset mid-frame
    mon_en = 1'b0;
    axi_wr(4'hC, 32'd1000, resp);
    for (int k = 0; k < 18; k++) begin
      axi_wr(4'h0, 32'(k), resp);
      check($sformatf("fill%0d_bresp", k), {30'b0, resp}, (k < 17) ? 32'd0 : 32'd2);
    end
    axi_rd(4'h8, rd);
    check("full_status", rd, 32'h0000_1005);
    check("midframe_tx", {31'b0, tx_w}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, tx_w}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_rd(4'h8, rd);
    check("post_reset_status", rd, 32'h0000_0002);
    axi_rd(4'hC, rd);
    check("post_reset_div", rd, 32'd868);

`ifdef UART_RX_EN
    loop_en = 1'b1; mon_en = 1'b1; mon_div = 8;
    axi_wr(4'hC, 32'd8, resp);
    exp_q.push_back(8'h3C);
    axi_wr(4'h0, 32'h3C, resp);
    wait_done(400);
    repeat (20) @(posedge clk);
    #1;
    axi_rd(4'h4, rd);
    check("rx_first_read", rd, 32'h8000_003C);
    axi_rd(4'h4, rd);
    check("rx_second_read", rd, 32'h0000_003C);
    exp_q.push_back(8'h11);
    axi_wr(4'h0, 32'h11, resp);
    exp_q.push_back(8'h22);
    axi_wr(4'h0, 32'h22, resp);
    wait_done(600);
    repeat (20) @(posedge clk);
    #1;
    axi_rd(4'h4, rd);
    check("rx_overrun_data", rd, 32'h8000_0022);
    axi_rd(4'h8, rd);
    check("rx_overrun_status", rd, 32'h0000_0012);
    axi_rd(4'h8, rd);
    check("rx_overrun_cleared", rd, 32'h0000_0002);
    loop_en = 1'b0;
    rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    axi_rd(4'h4, rd);
    check("rx_glitch_ignored", rd, 32'h0000_0022);
`else
    rx_drv = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    axi_rd(4'h4, rd);
    check("rxdata_disabled", rd, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
